// File: rtl/reg_bank_pkg.sv
// ============================================================================
// reg_bank_pkg : shared constants and types for the register-bank write path
// Revision 1.0
// ============================================================================
`default_nettype none

package reg_bank_pkg;

  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 32;
  localparam int CNT_W    = 8;

  typedef logic [ADDR_W-1:0] reg_idx_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  typedef struct packed {
    port_e             port;
    reg_idx_t          addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_idx_t idx);
    logic [NUM_REGS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pair_arbiter.sv
// ============================================================================
// rr_pair_arbiter : two-way round-robin arbiter, priority flips on each conflict
// Revision 1.0
// ============================================================================
`default_nettype none

module rr_pair_arbiter (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic toggle,
  output logic grant_a,
  output logic grant_b
);

  // rr=0 favours A, rr=1 favours B
  logic rr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= 1'b0;
    end else if (toggle) begin
      rr <= ~rr;
    end
  end

  assign grant_a = req_a & ~(req_b & rr);
  assign grant_b = req_b & ~(req_a & ~rr);

endmodule

`default_nettype wire

// File: rtl/reg_write_scheduler.sv
// ============================================================================
// reg_write_scheduler : two-requester write scheduler with collision buffer
//                       and hold scoreboard for the 16-entry register bank
// Revision 1.0
// ============================================================================
`default_nettype none

module reg_write_scheduler
  import reg_bank_pkg::*;
(
  input  logic                CLK,
  input  logic                Reset,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_data,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_data,
  input  logic                rsv_valid,
  input  logic [ADDR_W-1:0]   rsv_addr,
  output logic [NUM_REGS-1:0] wr_en,
  output logic [NUM_REGS-1:0] wr_sel_b,
  output logic [DATA_W-1:0]   wr_data_a,
  output logic [DATA_W-1:0]   wr_data_b,
  output logic [NUM_REGS-1:0] hold_Q,
  output logic [CNT_W-1:0]    conflict_cnt
);

  logic    pend_v, pend_v_n;
  wr_req_t pend, pend_n;
  logic    a_fire, b_fire, conflict, grant_a, grant_b;

  logic [NUM_REGS-1:0] en_n, sel_n, hold_n;
  logic [DATA_W-1:0]   da_n, db_n;
  logic [CNT_W-1:0]    cnt_n;

  assign a_ready  = ~pend_v;
  assign b_ready  = ~pend_v;
  assign a_fire   = a_valid & ~pend_v;
  assign b_fire   = b_valid & ~pend_v;
  assign conflict = a_fire & b_fire & (a_addr == b_addr);

  rr_pair_arbiter u_arb (
    .clk     (CLK),
    .rst_n   (Reset),
    .req_a   (a_fire),
    .req_b   (b_fire),
    .toggle  (conflict),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  always_comb begin
    en_n     = '0;
    sel_n    = '0;
    da_n     = wr_data_a;
    db_n     = wr_data_b;
    pend_n   = pend;
    pend_v_n = 1'b0;

    if (pend_v) begin
      en_n[pend.addr] = 1'b1;
      if (pend.port == PORT_B) begin
        sel_n[pend.addr] = 1'b1;
        db_n             = pend.data;
      end else begin
        da_n = pend.data;
      end
    end else begin
      // Grants only arbitrate a same-register collision; disjoint writes both go.
      if (a_fire && (!conflict || grant_a)) begin
        en_n[a_addr] = 1'b1;
        da_n         = a_data;
      end
      if (b_fire && (!conflict || grant_b)) begin
        en_n[b_addr]  = 1'b1;
        sel_n[b_addr] = 1'b1;
        db_n          = b_data;
      end
      if (conflict) begin
        pend_v_n = 1'b1;
        if (grant_a) begin
          pend_n.port = PORT_B;
          pend_n.addr = b_addr;
          pend_n.data = b_data;
        end else begin
          pend_n.port = PORT_A;
          pend_n.addr = a_addr;
          pend_n.data = a_data;
        end
      end
    end

    // A reservation landing on the same edge as a write keeps the bit set.
    hold_n = (hold_Q & ~en_n) | (rsv_valid ? reg_onehot(rsv_addr) : '0);
    cnt_n  = (conflict && (conflict_cnt != '1)) ? conflict_cnt + 1'b1 : conflict_cnt;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      wr_en        <= '0;
      wr_sel_b     <= '0;
      wr_data_a    <= '0;
      wr_data_b    <= '0;
      hold_Q       <= '0;
      conflict_cnt <= '0;
      pend_v       <= 1'b0;
      pend         <= '0;
    end else begin
      wr_en        <= en_n;
      wr_sel_b     <= sel_n;
      wr_data_a    <= da_n;
      wr_data_b    <= db_n;
      hold_Q       <= hold_n;
      conflict_cnt <= cnt_n;
      pend_v       <= pend_v_n;
      pend         <= pend_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_write_scheduler.sv
// ============================================================================
// tb_reg_write_scheduler : directed + random bench with queue-based reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_reg_write_scheduler;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        a_valid, b_valid, rsv_valid;
  logic        a_ready, b_ready;
  logic [3:0]  a_addr, b_addr, rsv_addr;
  logic [31:0] a_data, b_data;
  logic [15:0] wr_en, wr_sel_b, hold_Q;
  logic [31:0] wr_data_a, wr_data_b;
  logic [7:0]  conflict_cnt;

  reg_write_scheduler dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .rsv_valid    (rsv_valid),
    .rsv_addr     (rsv_addr),
    .wr_en        (wr_en),
    .wr_sel_b     (wr_sel_b),
    .wr_data_a    (wr_data_a),
    .wr_data_b    (wr_data_b),
    .hold_Q       (hold_Q),
    .conflict_cnt (conflict_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_b;
    int          addr;
    logic [31:0] data;
  } req_s;

  // Reference model: writes still owed to the bank plus visible output state
  req_s        waiting[$];
  bit          m_rr;
  int          m_cnt;
  logic [15:0] m_en, m_sel, m_hold;
  logic [31:0] m_la, m_lb;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  function automatic void model_clear();
    waiting.delete();
    m_rr = 0; m_cnt = 0;
    m_en = '0; m_sel = '0; m_hold = '0; m_la = '0; m_lb = '0;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  function automatic void model_edge();
    req_s iss[$];
    req_s ra, rb;
    ra = '{is_b: 0, addr: int'(a_addr), data: a_data};
    rb = '{is_b: 1, addr: int'(b_addr), data: b_data};
    if (waiting.size() > 0) begin
      iss.push_back(waiting.pop_front());
    end else if (a_valid && b_valid && a_addr == b_addr) begin
      iss.push_back(m_rr ? rb : ra);
      waiting.push_back(m_rr ? ra : rb);
      m_rr = !m_rr;
      if (m_cnt < 255) m_cnt++;
    end else begin
      if (a_valid) iss.push_back(ra);
      if (b_valid) iss.push_back(rb);
    end
    m_en = '0; m_sel = '0;
    foreach (iss[i]) begin
      m_en[iss[i].addr] = 1'b1;
      if (iss[i].is_b) begin
        m_sel[iss[i].addr] = 1'b1;
        m_lb = iss[i].data;
      end else begin
        m_la = iss[i].data;
      end
    end
    m_hold = m_hold & ~m_en;
    if (rsv_valid) m_hold[rsv_addr] = 1'b1;
  endfunction

  task automatic check_all(input string tag);
    check_eq({tag, ".wr_en"},    32'(wr_en),        32'(m_en));
    check_eq({tag, ".wr_sel_b"}, 32'(wr_sel_b),     32'(m_sel));
    check_eq({tag, ".data_a"},   wr_data_a,         m_la);
    check_eq({tag, ".data_b"},   wr_data_b,         m_lb);
    check_eq({tag, ".hold"},     32'(hold_Q),       32'(m_hold));
    check_eq({tag, ".cnt"},      32'(conflict_cnt), 32'(m_cnt));
    check_eq({tag, ".a_ready"},  32'(a_ready),      32'(waiting.size() == 0));
    check_eq({tag, ".b_ready"},  32'(b_ready),      32'(waiting.size() == 0));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input bit av, input int aa, input logic [31:0] ad,
                       input bit bv, input int ba, input logic [31:0] bd,
                       input bit rv, input int rs);
    a_valid = av; a_addr = 4'(aa); a_data = ad;
    b_valid = bv; b_addr = 4'(ba); b_data = bd;
    rsv_valid = rv; rsv_addr = 4'(rs);
  endtask

  initial begin
    Reset = 1'b0;
    drive(0, 0, '0, 0, 0, '0, 0, 0);
    model_clear();
    repeat (2) @(posedge CLK);
    #1;
    check_all("reset");
    Reset = 1'b1;

    // Collision on r3, then async reset before the loser issues
    drive(1, 3, 32'h11111111, 1, 3, 32'h22222222, 0, 0);
    step("t1_hs");
    check_eq("t1_win_en", 32'(wr_en), 32'h0008);
    drive(0, 0, '0, 0, 0, '0, 0, 0);
    #2;
    Reset = 1'b0;
    model_clear();
    #1;
    check_all("t1_in_reset");
    @(posedge CLK);
    #1;
    Reset = 1'b1;
    step("t1_after");
    check_eq("t1_no_r3", 32'(wr_en), 32'h0000);
    check_eq("t1_a_ready", 32'(a_ready), 32'h1);

    // Disjoint dual write
    drive(1, 2, 32'hDEADBEEF, 1, 9, 32'h0000CAFE, 0, 0);
    step("t2");
    check_eq("t2_en", 32'(wr_en), 32'h0204);
    check_eq("t2_sel", 32'(wr_sel_b), 32'h0200);
    check_eq("t2_da", wr_data_a, 32'hDEADBEEF);
    check_eq("t2_db", wr_data_b, 32'h0000CAFE);

    // Collision on r5 twice: A wins first, then B
    drive(1, 5, 32'hAAAA0000, 1, 5, 32'hBBBB0000, 0, 0);
    step("t3_c1");
    check_eq("t3_c1_en", 32'(wr_en), 32'h0020);
    check_eq("t3_c1_sel", 32'(wr_sel_b), 32'h0000);
    check_eq("t3_c1_ready", 32'(a_ready), 32'h0);
    step("t3_c1_pend");
    check_eq("t3_c1p_sel", 32'(wr_sel_b), 32'h0020);
    check_eq("t3_c1p_db", wr_data_b, 32'hBBBB0000);
    check_eq("t3_c1p_cnt", 32'(conflict_cnt), 32'h1);
    step("t3_c2");
    check_eq("t3_c2_sel", 32'(wr_sel_b), 32'h0020);
    drive(0, 0, '0, 0, 0, '0, 0, 0);
    step("t3_c2_pend");
    check_eq("t3_c2p_sel", 32'(wr_sel_b), 32'h0000);
    check_eq("t3_c2p_da", wr_data_a, 32'hAAAA0000);

    // Hold scoreboard
    drive(0, 0, '0, 0, 0, '0, 1, 7);
    step("t5_rsv");
    check_eq("t5_h7_set", 32'(hold_Q[7]), 32'h1);
    drive(1, 7, 32'h77777777, 0, 0, '0, 0, 0);
    step("t5_wr");
    check_eq("t5_h7_clr", 32'(hold_Q[7]), 32'h0);
    drive(1, 4, 32'h44444444, 0, 0, '0, 1, 4);
    step("t5_coinc");
    check_eq("t5_h4_keep", 32'(hold_Q[4]), 32'h1);
    drive(0, 0, '0, 0, 0, '0, 0, 0);
    step("t5_idle");

    // Saturation: ~310 collisions back-to-back
    for (int i = 0; i < 620; i++) begin
      drive(1, 1, $urandom, 1, 1, $urandom, 0, 0);
      step("t4");
    end
    check_eq("t4_sat", 32'(conflict_cnt), 32'd255);

    // Randomized traffic focused on a few registers to provoke collisions
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1), ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 15), $urandom,
            $urandom_range(0, 1), $urandom_range(0, 3), $urandom,
            ($urandom_range(0, 3) == 0), $urandom_range(0, 15));
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
